hex_out_iface: RTL and testbench
================================

Name: hex_out_iface

Overview:
Board-side output interface for the CPU. It captures a 16-bit result word and the Z/N/V status flags on a load strobe, and drives the DE1-SoC HEX displays (active-low segments). Each hex digit whose value changed on the last capture flashes for a programmable time, so the operator can see which nibbles an instruction updated. It sits between the cpu outputs (out, Z, N, V, w-derived strobe) and HEX0..HEX5 in the top level.

Parameters:
HOLD_CYCLES, 25000000, length of the flash window in clk cycles (>=1)
BLINK_DIV, 6250000, blink half-period in clk cycles (>=1)

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-high; clears all state
load  input  1  capture strobe, sampled at posedge clk
din  input  16  value to display
Z  input  1  zero flag, captured with din
N  input  1  negative flag, captured with din
V  input  1  overflow flag, captured with din
HEX0..HEX3  output  7 each  digits of the captured value, nibble 0..3, active-low, bit order 6..0 = middle, upper-left, lower-left, bottom, lower-right, upper-right, top
HEX4  output  7  always 7'b1111111
HEX5  output  7  flags: bit0 = ~Z, bit6 = ~N, bit3 = ~V, other bits 1
busy  output  1  high while in FLASH

Behaviour:
- Reset (async, active-high): shown = 16'h0000, flags = 0, mask = 4'b0000, state = IDLE, counters = 0, phase = on. Outputs: HEX0..3 = 7'b1000000 ("0"), HEX5 = 7'b1111111, busy = 0. Reset mid-FLASH aborts the flash immediately.
- Internal regs: shown[15:0], flag regs, mask[3:0] (one bit per nibble), hold counter, blink counter, phase bit, state {IDLE, FLASH}.
- HEX outputs are combinational from the registers. A capture at edge k is visible right after edge k (zero added latency).
- Digit encoding: 0-9, A, b, C, d, E, F. The codes are 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0011000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110.
- On load=1 at an edge, in either state:
  - shown <= din and flags <= {Z,N,V}.
  - newmask(i) = (shown nibble i != din nibble i).
  - In IDLE: if newmask != 0, then mask <= newmask, state <= FLASH, hold <= HOLD_CYCLES-1, blink <= 0, phase <= on. If newmask == 0, stay IDLE with mask unchanged (0).
  - In FLASH: mask <= mask | newmask, hold <= HOLD_CYCLES-1 (window restarts), blink <= 0, phase <= on. This applies even when newmask == 0.
- FLASH, with no load:
  - Blink counter increments. At BLINK_DIV-1 it wraps to 0 and toggles phase.
  - Hold counter decrements. On the edge where hold == 0: state <= IDLE, mask <= 0, phase <= on.
  - The FLASH window is therefore exactly HOLD_CYCLES cycles from the capture edge.
- Digit i output = 7'b1111111 when state == FLASH, mask[i] = 1, and phase = off. Otherwise it is the encoding of shown nibble i.
- busy = (state == FLASH).
- Flags never blink. HEX5 updates only on load.
- Counter widths are sized by $clog2 of their parameters. No wrap-around occurs beyond the rules above.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: HEX3, HEX2 and HEX1 show 7'b1111111 when their nibble and all higher nibbles of shown are zero. HEX0 is always displayed. Blanking applies before blink, so a blanked digit stays blank.
- Undefined: all four digits are always displayed, including leading zeros (reset shows "0000").

Test Plan:
(HOLD_CYCLES=8, BLINK_DIV=2)
1. Assert reset, then release -> HEX0..3 = 1000000, HEX4 = 1111111, HEX5 = 1111111, busy = 0.
2. Load din=16'h00A5, Z=0, N=0, V=0 -> immediately HEX0 = 0010010 and HEX1 = 0001000; busy = 1 for exactly 8 cycles. HEX0/HEX1 show visible for 2 cycles, 1111111 for 2, visible for 2, 1111111 for 2, then steady. HEX2/HEX3 stay 1000000 throughout.
3. From IDLE showing 16'h00A5, load 16'h00A5 -> busy stays 0 and no digit blinks.
4. During a FLASH from 0000->00A5, at cycle 5 load 16'h30A5 -> mask = 4'b1011, window restarts (busy high 8 more cycles), HEX3 = 0110000 blinks together with HEX0/HEX1.
5. Load with Z=1, N=0, V=1 -> HEX5 = 7'b1110110. Then load with Z=0, N=1, V=0 -> HEX5 = 7'b0111111.
6. Assert reset asynchronously mid-FLASH (between clock edges) -> busy = 0 and HEX0..3 = 1000000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hex_out_iface.sv
// Purpose: captures a 16-bit result plus Z/N/V and drives the active-low HEX displays; changed nibbles flash.
// Latency: a capture is visible on HEX right after the load edge, and the HEX outputs are combinational from registers.
// Backpressure: none, load is accepted every cycle. Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
module hex_out_iface #(
    parameter int HOLD_CYCLES = 25000000,
    parameter int BLINK_DIV   = 6250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] din,
    input  logic        Z,
    input  logic        N,
    input  logic        V,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        busy
);

    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic {IDLE, FLASH} state_t;

    state_t              state;
    logic [15:0]         shown;
    logic                z_q, n_q, v_q;
    logic [3:0]          mask;
    logic [HOLD_W-1:0]   hold;
    logic [BLINK_W-1:0]  blink;
    logic                phase_on;
    logic [3:0]          new_mask;
    logic [3:0]          lz_blank;
    logic [6:0]          hex_d [4];

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Nibbles that differ between the displayed value and the incoming word.
    always_comb begin
        new_mask = '0;
        for (int i = 0; i < 4; i++) begin
            new_mask[i] = (shown[4*i +: 4] != din[4*i +: 4]);
        end
    end

    // Capture register, flash-window state machine and blink timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shown    <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            mask     <= '0;
            hold     <= '0;
            blink    <= '0;
            phase_on <= 1'b1;
        end else if (load) begin
            shown <= din;
            z_q   <= Z;
            n_q   <= N;
            v_q   <= V;
            if (state == IDLE) begin
                // An unchanged value needs no flash window.
                if (|new_mask) begin
                    mask     <= new_mask;
                    state    <= FLASH;
                    hold     <= HOLD_LAST;
                    blink    <= '0;
                    phase_on <= 1'b1;
                end
            end else begin
                // Any load during a flash restarts the window and accumulates changed digits.
                mask     <= mask | new_mask;
                hold     <= HOLD_LAST;
                blink    <= '0;
                phase_on <= 1'b1;
            end
        end else if (state == FLASH) begin
            if (hold == '0) begin
                state    <= IDLE;
                mask     <= '0;
                phase_on <= 1'b1;
                blink    <= '0;
            end else begin
                hold <= hold - 1'b1;
                if (blink == BLINK_LAST) begin
                    blink    <= '0;
                    phase_on <= ~phase_on;
                end else begin
                    blink <= blink + 1'b1;
                end
            end
        end
    end

    // Leading-zero suppression for the upper three digits; HEX0 always shows.
    always_comb begin
        lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank[3] = (shown[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] && (shown[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] && (shown[7:4] == 4'h0);
`endif
    end

    // Digit drive: blanked digits stay dark, flashing digits go dark in the off phase.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hex_d[i] = seg7(shown[4*i +: 4]);
            if (lz_blank[i] || ((state == FLASH) && mask[i] && !phase_on)) begin
                hex_d[i] = 7'b1111111;
            end
        end
    end

    assign HEX0 = hex_d[0];
    assign HEX1 = hex_d[1];
    assign HEX2 = hex_d[2];
    assign HEX3 = hex_d[3];
    assign HEX4 = 7'b1111111;
    assign HEX5 = {~n_q, 2'b11, ~v_q, 2'b11, ~z_q};
    assign busy = (state == FLASH);

endmodule

// File: tb/tb_hex_out_iface.sv
// Purpose: directed bench for hex_out_iface with HOLD_CYCLES=8, BLINK_DIV=2 (default build, no digit blanking).
// Latency: outputs sampled 1ns after each rising edge; reset checked between edges.
// Backpressure: not applicable.
module tb_hex_out_iface;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] SA   = 7'b0001000;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic        Z = 1'b0, N = 1'b0, V = 1'b0;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Expected visibility of a flashing digit and busy, j edges after the capture edge.
    bit vis_tbl  [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    bit busy_tbl [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    hex_out_iface #(.HOLD_CYCLES(8), .BLINK_DIV(2)) dut (
        .clk(clk), .reset(reset), .load(load), .din(din),
        .Z(Z), .N(N), .V(V),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic z, input logic n, input logic v);
        din = d; Z = z; N = n; V = v; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        // 1: reset state
        tick(); tick();
        check("rst_hex0", 16'(HEX0), 16'(S0));
        check("rst_hex1", 16'(HEX1), 16'(S0));
        check("rst_hex2", 16'(HEX2), 16'(S0));
        check("rst_hex3", 16'(HEX3), 16'(S0));
        check("rst_hex4", 16'(HEX4), 16'(SOFF));
        check("rst_hex5", 16'(HEX5), 16'(SOFF));
        check("rst_busy", 16'(busy), 16'd0);
        #2 reset = 1'b0;
        tick();
        check("idle_busy", 16'(busy), 16'd0);

        // 2: 0000 -> 00A5 flashes digits 0 and 1 for exactly 8 cycles
        do_load(16'h00A5, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("t2_hex0_%0d", j), 16'(HEX0), 16'(vis_tbl[j] ? S5 : SOFF));
            check($sformatf("t2_hex1_%0d", j), 16'(HEX1), 16'(vis_tbl[j] ? SA : SOFF));
            check($sformatf("t2_hex2_%0d", j), 16'(HEX2), 16'(S0));
            check($sformatf("t2_hex3_%0d", j), 16'(HEX3), 16'(S0));
            check($sformatf("t2_busy_%0d", j), 16'(busy), 16'(busy_tbl[j]));
            tick();
        end

        // 3: reloading the same value does not start a flash
        do_load(16'h00A5, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t3_busy_%0d", j), 16'(busy), 16'd0);
            check($sformatf("t3_hex0_%0d", j), 16'(HEX0), 16'(S5));
            check($sformatf("t3_hex1_%0d", j), 16'(HEX1), 16'(SA));
            tick();
        end

        // 4: second load mid-flash restarts the window and adds digit 3
        reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        do_load(16'h00A5, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j < 5; j++) tick();
        check("t4_busy_pre", 16'(busy), 16'd1);
        do_load(16'h30A5, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("t4_hex0_%0d", j), 16'(HEX0), 16'(vis_tbl[j] ? S5 : SOFF));
            check($sformatf("t4_hex1_%0d", j), 16'(HEX1), 16'(vis_tbl[j] ? SA : SOFF));
            check($sformatf("t4_hex2_%0d", j), 16'(HEX2), 16'(S0));
            check($sformatf("t4_hex3_%0d", j), 16'(HEX3), 16'(vis_tbl[j] ? S3 : SOFF));
            check($sformatf("t4_busy_%0d", j), 16'(busy), 16'(busy_tbl[j]));
            tick();
        end

        // 5: flag display, updated only by load
        do_load(16'h30A5, 1'b1, 1'b0, 1'b1);
        check("t5_hex5_zv", 16'(HEX5), 16'(7'b1110110));
        check("t5_busy_zv", 16'(busy), 16'd0);
        Z = 1'b0; N = 1'b1; V = 1'b0;
        tick();
        check("t5_hex5_noload", 16'(HEX5), 16'(7'b1110110));
        do_load(16'h30A5, 1'b0, 1'b1, 1'b0);
        check("t5_hex5_n", 16'(HEX5), 16'(7'b0111111));
        check("t5_hex4", 16'(HEX4), 16'(SOFF));

        // 6: asynchronous reset between edges aborts a flash
        do_load(16'h1234, 1'b0, 1'b0, 1'b0);
        tick();
        check("t6_busy_pre", 16'(busy), 16'd1);
        #3 reset = 1'b1;
        #1;
        check("t6_busy", 16'(busy), 16'd0);
        check("t6_hex0", 16'(HEX0), 16'(S0));
        check("t6_hex1", 16'(HEX1), 16'(S0));
        check("t6_hex2", 16'(HEX2), 16'(S0));
        check("t6_hex3", 16'(HEX3), 16'(S0));
        check("t6_hex5", 16'(HEX5), 16'(SOFF));
        #2 reset = 1'b0;
        tick();
        check("t6_busy_post", 16'(busy), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
